// File: rtl/ksa_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder/subtractor family.
// Holds the prefix-level count and the per-level span used to elaborate the pipes.
package ksa_pkg;

  function automatic int ksa_levels(input int bits);
    int lv;
    lv = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < bits) begin
        lv = i + 32'sd1;
      end
    end
    return lv;
  endfunction

  function automatic int span(input int k);
    return 32'sd1 << (k - 32'sd1);
  endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One registered Kogge-Stone prefix level: combines each group with the one SPAN bits below.
// The raw propagate (p0) and carry-in ride alongside for the final sum.
module ksa_prefix_stage #(
  parameter int BITS = 64,
  parameter int SPAN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            vld_i,
  input  logic [BITS-1:0] p_i,
  input  logic [BITS-1:0] g_i,
  input  logic [BITS-1:0] p0_i,
  input  logic            cin_i,
  output logic            vld_o,
  output logic [BITS-1:0] p_o,
  output logic [BITS-1:0] g_o,
  output logic [BITS-1:0] p0_o,
  output logic            cin_o
);

  logic [BITS-1:0] p_nxt_s;
  logic [BITS-1:0] g_nxt_s;

  // Group combine; bits below SPAN already cover their full prefix and pass through
  always_comb begin
    p_nxt_s = p_i;
    g_nxt_s = g_i;
    for (int i = SPAN; i < BITS; i++) begin
      g_nxt_s[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      p_nxt_s[i] = p_i[i] & p_i[i-SPAN];
    end
  end

  // Level register, frozen with the rest of the pipe when en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      p_o   <= {BITS{1'b0}};
      g_o   <= {BITS{1'b0}};
      p0_o  <= {BITS{1'b0}};
      cin_o <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
      p_o   <= p_nxt_s;
      g_o   <= g_nxt_s;
      p0_o  <= p0_i;
      cin_o <= cin_i;
    end
  end

endmodule

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin computed as a + ~b + ~bin.
// Stage 0, LEVELS prefix stages and a result stage, with one global advance enable.
module ksa_sub_pipe
  import ksa_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int LEVELS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] diff,
  output logic            bout
);

  if (LEVELS != ksa_levels(BITS)) begin : g_levels_check
    $error("ksa_sub_pipe: LEVELS must equal ceil(log2(BITS))");
  end

  logic            en_s;
  logic [BITS-1:0] p_raw_s;
  logic [BITS-1:0] g_raw_s;
  logic            cin0_s;

  logic [BITS-1:0] p_r;
  logic [BITS-1:0] g_r;
  logic [BITS-1:0] p0_r;
  logic            cin_r;
  logic            vld_r;

  logic [BITS-1:0] p_s   [0:LEVELS];
  logic [BITS-1:0] g_s   [0:LEVELS];
  logic [BITS-1:0] p0_s  [0:LEVELS];
  logic            cin_s [0:LEVELS];
  logic            vld_s [0:LEVELS];

  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;

  // Operand pre-processing; the carry-in is folded in as a generate below bit 0
  always_comb begin
    cin0_s     = ~bin;
    p_raw_s    = a ^ ~b;
    g_raw_s    = a & ~b;
    g_raw_s[0] = (a[0] & ~b[0]) | (p_raw_s[0] & cin0_s);
  end

  // Stage 0 register; an idle input cycle loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 1'b0;
      p_r   <= {BITS{1'b0}};
      g_r   <= {BITS{1'b0}};
      p0_r  <= {BITS{1'b0}};
      cin_r <= 1'b0;
    end else if (en_s) begin
      vld_r <= in_valid;
      p_r   <= p_raw_s;
      g_r   <= g_raw_s;
      p0_r  <= p_raw_s;
      cin_r <= cin0_s;
    end
  end

  assign vld_s[0] = vld_r;
  assign p_s[0]   = p_r;
  assign g_s[0]   = g_r;
  assign p0_s[0]  = p0_r;
  assign cin_s[0] = cin_r;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ksa_prefix_stage #(
      .BITS (BITS),
      .SPAN (span(k))
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_s),
      .vld_i (vld_s[k-1]),
      .p_i   (p_s[k-1]),
      .g_i   (g_s[k-1]),
      .p0_i  (p0_s[k-1]),
      .cin_i (cin_s[k-1]),
      .vld_o (vld_s[k]),
      .p_o   (p_s[k]),
      .g_o   (g_s[k]),
      .p0_o  (p0_s[k]),
      .cin_o (cin_s[k])
    );
  end

  // Result stage: carry into bit i is the full prefix generate of bit i-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= {BITS{1'b0}};
      bout      <= 1'b0;
    end else if (en_s) begin
      out_valid <= vld_s[LEVELS];
      diff      <= p0_s[LEVELS] ^ {g_s[LEVELS][BITS-2:0], cin_s[LEVELS]};
      bout      <= ~g_s[LEVELS][BITS-1];
    end
  end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe at BITS=8: directed table, handshake corner cases, async reset,
// then a random scoreboard against an integer-arithmetic reference.
module tb_ksa_sub_pipe;

  localparam int BITS   = 8;
  localparam int LEVELS = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] diff;
  logic            bout;

  ksa_sub_pipe #(.BITS(BITS), .LEVELS(LEVELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int out_cnt = 0;
  logic mon_en = 1'b0;

  logic [16:0] in_q [$];
  logic [8:0]  obs_q [$];
  int          obs_cyc [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_diff;
  logic       prev_bout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction; a negative result means a borrow out
  function automatic logic [8:0] ref_sub(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
    int d;
    d = int'(ra) - int'(rb) - int'(rbin);
    return {(d < 0) ? 1'b1 : 1'b0, d[7:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      if (prev_stall) begin
        chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_hold_diff", {56'd0, diff}, {56'd0, prev_diff});
        chk("stall_hold_bout", {63'd0, bout}, {63'd0, prev_bout});
      end
      if (in_valid && in_ready) in_q.push_back({a, b, bin});
      if (out_valid && out_ready) begin
        chk("orphan_result", {63'd0, (in_q.size() > 0)}, 64'd1);
        if (in_q.size() > 0) begin
          logic [16:0] t;
          logic [8:0]  e;
          t = in_q.pop_front();
          e = ref_sub(t[16:9], t[8:1], t[0]);
          chk("sb_diff", {56'd0, diff}, {56'd0, e[7:0]});
          chk("sb_bout", {63'd0, bout}, {63'd0, e[8]});
        end
        obs_q.push_back({bout, diff});
        obs_cyc.push_back(cyc);
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_diff  = diff;
      prev_bout  = bout;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic sbin);
    @(posedge clk); #1;
    in_valid = 1'b1; a = sa; b = sb; bin = sbin;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((in_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", {63'd0, (t < 100)}, 64'd1);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_arrives", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    int n;
    int acc;
    int base;
    int stale;
    logic [7:0] hd;
    logic       hb;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tbl[4] = '{8'd1,  8'd0,  1'b0, 8'd1,  1'b0};
    tbl[5] = '{8'd2,  8'd1,  1'b0, 8'd1,  1'b0};
    tbl[6] = '{8'd3,  8'd1,  1'b0, 8'd2,  1'b0};
    tbl[7] = '{8'd200, 8'd100, 1'b0, 8'd100, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_diff", {56'd0, diff}, 64'd0);
    chk("reset_bout", {63'd0, bout}, 64'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;

    // Latency: the accepting edge counts as edge 1, result valid after edge LEVELS+2
    send(tbl[0].a, tbl[0].b, tbl[0].bin);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency_edges", n, LEVELS + 2);
    wait_drain();

    // Directed table, applied back-to-back
    obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].bin);
    idle();
    wait_drain();
    chk("table_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      chk($sformatf("table%0d_diff", i), {56'd0, obs_q[i][7:0]}, {56'd0, tbl[i].diff});
      chk($sformatf("table%0d_bout", i), {63'd0, obs_q[i][8]}, {63'd0, tbl[i].bout});
      chk($sformatf("table%0d_cycle", i), obs_cyc[i] - obs_cyc[0], i);
    end

    // Stall with a result waiting and a second beat behind it
    obs_q.delete(); obs_cyc.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'h40, 8'h11, 1'b1);
    send(8'h10, 8'h20, 1'b0);
    idle();
    wait_out_valid();
    hd = diff; hb = bout;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_diff", {56'd0, diff}, {56'd0, hd});
      chk("stall_bout", {63'd0, bout}, {63'd0, hb});
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();
    chk("stall_beats_out", obs_q.size(), 2);

    // Bubble pattern 1,0,1
    obs_q.delete(); obs_cyc.delete();
    send(8'h33, 8'h44, 1'b0);
    idle();
    send(8'h99, 8'h09, 1'b1);
    idle();
    wait_drain();
    chk("bubble_count", obs_q.size(), 2);
    if (obs_q.size() == 2) chk("bubble_gap", obs_cyc[1] - obs_cyc[0], 2);

    // Asynchronous reset with beats in flight and a result held at the output
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 8'h10, 1'b0);
    idle();
    wait_out_valid();
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_diff", {56'd0, diff}, 64'd0);
    chk("async_rst_bout", {63'd0, bout}, 64'd0);
    in_q.delete();
    out_ready = 1'b1;
    #13 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", stale, 0);
    mon_en = 1'b1;

    // Random traffic with random backpressure
    base = out_cnt;
    acc = 0;
    n = 0;
    while (acc < 10000 && n < 60000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("random_results", out_cnt - base, 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
